// File: rtl/conv_ctrl_fsm_pkg.sv
// Shared types and defaults for the convolution memory-control FSM.
package conv_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        PROC  = 3'd2,
        DRAIN = 3'd3,
        READ  = 3'd4
    } state_t;

    localparam int DEF_NB_ADDRESS   = 10;
    localparam int DEF_NB_IMAGE     = 10;
    localparam int DEF_CONV_LATENCY = 6;
    localparam int DEF_KERNEL       = 3;

    // Never returns 0 so a single-bank build still gets a 1-bit index.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/conv_ctrl_fsm_if.sv
// Host-side and memory-side signal bundle of the convolution control FSM.
interface conv_ctrl_fsm_if #(
    parameter int NB_ADDRESS = 10,
    parameter int NB_IMAGE   = 10,
    parameter int NB_BANK    = 2
);
    logic                  i_load;
    logic                  i_SoP;
    logic                  i_valid;
    logic [NB_IMAGE-1:0]   i_imgLength;
    logic [NB_ADDRESS-1:0] o_readAdd;
    logic [NB_ADDRESS-1:0] o_writeAdd;
    logic                  o_wrEn;
    logic [NB_BANK-1:0]    o_bankSel;
    logic                  o_valid_toCONV;
    logic                  o_SOP;
    logic                  o_EoP;
    logic                  o_changeBlock;
    logic                  o_err;
    logic [2:0]            o_state;

    modport master (
        output i_load, i_SoP, i_valid, i_imgLength,
        input  o_readAdd, o_writeAdd, o_wrEn, o_bankSel,
        input  o_valid_toCONV, o_SOP, o_EoP,
        input  o_changeBlock, o_err, o_state
    );

    modport slave (
        input  i_load, i_SoP, i_valid, i_imgLength,
        output o_readAdd, o_writeAdd, o_wrEn, o_bankSel,
        output o_valid_toCONV, o_SOP, o_EoP,
        output o_changeBlock, o_err, o_state
    );
endinterface

// File: rtl/conv_ctrl_fsm_valid_edge_det.sv
// Registered rising-edge detector; a level held high yields one pulse.
module valid_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);
    logic prev;

    always_ff @(posedge clk) begin
        if (rst) prev <= 1'b0;
        else     prev <= din;
    end

    assign rise = din & ~prev;
endmodule

// File: rtl/conv_ctrl_fsm.sv
// Load / process / drain / readback sequencer for banked line-buffer memory.
module conv_ctrl_fsm
    import conv_ctrl_pkg::*;
#(
    parameter int NB_ADDRESS   = DEF_NB_ADDRESS,
    parameter int NB_IMAGE     = DEF_NB_IMAGE,
    parameter int CONV_LATENCY = DEF_CONV_LATENCY,
    parameter int KERNEL       = DEF_KERNEL,
    parameter int N_BANKS      = 3,
    parameter int NB_BANK      = clog2(N_BANKS)
) (
    input logic            i_CLK,
    input logic            i_reset,
    conv_ctrl_fsm_if.slave bus
);
    localparam int CW = NB_ADDRESS + 1;
    localparam logic [CW-1:0] K_C   = CW'(KERNEL);
    localparam logic [CW-1:0] LAT_C = CW'(CONV_LATENCY);
    localparam logic [NB_BANK-1:0] LAST_BANK = NB_BANK'(N_BANKS - 1);

    state_t state_q, state_d;
    logic [CW-1:0] n_q, n_d, ld_q, ld_d, rd_q, rd_d;
    logic [CW-1:0] wr_q, wr_d, lat_q, lat_d;
    logic [NB_BANK-1:0] bank_q, bank_d, bank_nx;
    logic wren_q, wren_d, vconv_q, vconv_d, sop_q, sop_d;
    logic eop_q, eop_d, cb_q, cb_d, err_q, err_d;
    logic [NB_IMAGE-1:0] img;
    logic rise, len_ok, go;

    valid_edge_det u_edge (
        .clk  (i_CLK),
        .rst  (i_reset),
        .din  (bus.i_valid),
        .rise (rise)
    );

    assign img     = bus.i_imgLength;
    assign len_ok  = CW'(img) >= K_C;
    assign bank_nx = (bank_q == LAST_BANK) ? '0 : bank_q + 1'b1;
    // Exactly one of the three legal requests, gated by the EoP phase.
    assign go = eop_q ? (~bus.i_load & ~bus.i_SoP)
                      : (bus.i_load ^ bus.i_SoP);

    always_ff @(posedge i_CLK) begin
        if (i_reset) begin
            state_q <= IDLE;
            n_q     <= '0;
            ld_q    <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            lat_q   <= '0;
            bank_q  <= '0;
            wren_q  <= 1'b0;
            vconv_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            cb_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            ld_q    <= ld_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            lat_q   <= lat_d;
            bank_q  <= bank_d;
            wren_q  <= wren_d;
            vconv_q <= vconv_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            cb_q    <= cb_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        ld_d    = ld_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        lat_d   = lat_q;
        bank_d  = bank_q;
        wren_d  = 1'b0;
        vconv_d = vconv_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        cb_d    = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                ld_d  = '0;
                rd_d  = '0;
                wr_d  = '0;
                lat_d = '0;
                if (bus.i_load && bus.i_SoP) begin
                    err_d = 1'b1;
                end else if (go && !len_ok) begin
                    err_d = 1'b1;
                end else if (go) begin
                    n_d = CW'(img);
                    if (bus.i_load) begin
                        state_d = LOAD;
                    end else if (bus.i_SoP) begin
                        state_d = PROC;
                        sop_d   = 1'b1;
                        vconv_d = 1'b1;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            LOAD: begin
                // Address advances after the write cycle it was shown in.
                if (wren_q) ld_d = ld_q + 1'b1;
                if (rise && ld_q < n_q) wren_d = 1'b1;
                if (ld_q == n_q && !wren_q && !bus.i_load) begin
                    cb_d    = 1'b1;
                    bank_d  = bank_nx;
                    state_d = IDLE;
                end
            end
            PROC: begin
                lat_d = lat_q + 1'b1;
                if (rd_q < n_q - 1'b1) rd_d = rd_q + 1'b1;
                if (wren_q && wr_q == n_q - K_C) begin
                    vconv_d = 1'b0;
                    sop_d   = 1'b0;
                    eop_d   = 1'b1;
                    state_d = DRAIN;
                end else if (lat_q + 1'b1 >= LAT_C) begin
                    wren_d = 1'b1;
                    if (wren_q) wr_d = wr_q + 1'b1;
                end
            end
            DRAIN: begin
                if (!bus.i_SoP) state_d = IDLE;
            end
            READ: begin
                if (rise && rd_q < n_q) rd_d = rd_q + 1'b1;
                if (rd_q == n_q) begin
                    eop_d   = 1'b0;
                    cb_d    = 1'b1;
                    bank_d  = bank_nx;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.o_readAdd  = '0;
        bus.o_writeAdd = '0;
        unique case (state_q)
            LOAD: bus.o_writeAdd = ld_q[NB_ADDRESS-1:0];
            PROC, DRAIN: begin
                bus.o_readAdd  = rd_q[NB_ADDRESS-1:0];
                bus.o_writeAdd = wr_q[NB_ADDRESS-1:0];
            end
            READ: bus.o_readAdd = rd_q[NB_ADDRESS-1:0];
            default: ;
        endcase
    end

    assign bus.o_wrEn         = wren_q;
    assign bus.o_bankSel      = bank_q;
    assign bus.o_valid_toCONV = vconv_q;
    assign bus.o_SOP          = sop_q;
    assign bus.o_EoP          = eop_q;
    assign bus.o_changeBlock  = cb_q;
    assign bus.o_err          = err_q;
    assign bus.o_state        = state_q;
endmodule

// File: tb/tb_conv_ctrl_fsm.sv
// Randomised scenario bench for conv_ctrl_fsm against a transaction model.
module tb_conv_ctrl_fsm;
    localparam int LAT = 6;
    localparam int K   = 3;
    localparam int NBK = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_ctrl_fsm_if #(.NB_ADDRESS(10), .NB_IMAGE(10), .NB_BANK(2)) bus ();

    conv_ctrl_fsm #(
        .NB_ADDRESS(10), .NB_IMAGE(10), .CONV_LATENCY(LAT),
        .KERNEL(K), .N_BANKS(NBK), .NB_BANK(2)
    ) dut (
        .i_CLK   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    int bank_exp = 0;
    int wr_q[$];
    int cb_cnt = 0;
    int err_cnt = 0;

    task automatic tick_mon();
        @(posedge clk);
        #1;
        if (bus.o_wrEn) wr_q.push_back(int'(bus.o_writeAdd));
        if (bus.o_changeBlock) cb_cnt++;
        if (bus.o_err) err_cnt++;
    endtask

    task automatic idle_inputs();
        bus.i_load = 1'b0;
        bus.i_SoP = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_imgLength = 10'd8;
    endtask

    task automatic check_all_zero(input string tag);
        logic [31:0] got;
        got = {bus.o_readAdd, bus.o_writeAdd, bus.o_bankSel,
               bus.o_wrEn, bus.o_valid_toCONV, bus.o_SOP,
               bus.o_EoP, bus.o_changeBlock, bus.o_err, bus.o_state};
        checks++;
        if (got !== 32'd0) begin
            errors++;
            $display("FAIL %s outputs got %h exp 0", tag, got);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (3) tick_mon();
        check_all_zero("reset_hold");
        rst = 1'b0;
        tick_mon();
        check_all_zero("reset_release");
        bank_exp = 0;
    endtask

    task automatic do_load(input int n, input int extra, input string tag);
        wr_q.delete();
        cb_cnt = 0;
        bus.i_imgLength = 10'(n);
        bus.i_load = 1'b1;
        tick_mon();
        checks++;
        if (bus.o_state !== 3'd1) begin
            errors++;
            $display("FAIL %s enter got %0d exp 1", tag, bus.o_state);
        end
        for (int p = 0; p < n + extra; p++) begin
            bus.i_valid = 1'b1;
            repeat ($urandom_range(1, 3)) tick_mon();
            bus.i_valid = 1'b0;
            if (p == n / 2) bus.i_imgLength = 10'($urandom_range(0, 1023));
            repeat ($urandom_range(1, 3)) tick_mon();
        end
        checks++;
        if (bus.o_state !== 3'd1) begin
            errors++;
            $display("FAIL %s hold got %0d exp 1", tag, bus.o_state);
        end
        bus.i_load = 1'b0;
        bus.i_imgLength = 10'(n);
        repeat (4) tick_mon();
        bank_exp = (bank_exp + 1) % NBK;
        begin
            int bad;
            bad = (wr_q.size() != n) ? 1 : 0;
            foreach (wr_q[i]) if (wr_q[i] != i) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL %s writes got %0d exp %0d bad %0d",
                         tag, wr_q.size(), n, bad);
            end
        end
        checks++;
        if (cb_cnt !== 1) begin
            errors++;
            $display("FAIL %s change_block got %0d exp 1", tag, cb_cnt);
        end
        checks++;
        if (int'(bus.o_bankSel) !== bank_exp || bus.o_state !== 3'd0) begin
            errors++;
            $display("FAIL %s bank/state got %0d/%0d exp %0d/0",
                     tag, bus.o_bankSel, bus.o_state, bank_exp);
        end
    endtask

    task automatic do_proc(input int n, input string tag);
        int last;
        last = LAT + n - K + 1;
        bus.i_imgLength = 10'(n);
        bus.i_SoP = 1'b1;
        for (int k = 0; k <= last; k++) begin
            logic [6:0] exp_f, got_f;
            logic exp_we;
            int exp_ra;
            tick_mon();
            if (k == 2) bus.i_imgLength = 10'($urandom_range(0, 1023));
            exp_we = (k >= LAT) && (k < last);
            exp_ra = (k < n - 1) ? k : n - 1;
            exp_f = (k < last) ? {3'd2, 1'b1, 1'b1, exp_we, 1'b0}
                               : {3'd3, 1'b0, 1'b0, 1'b0, 1'b1};
            got_f = {bus.o_state, bus.o_SOP, bus.o_valid_toCONV,
                     bus.o_wrEn, bus.o_EoP};
            checks++;
            if (got_f !== exp_f) begin
                errors++;
                $display("FAIL %s flags t0+%0d got %b exp %b",
                         tag, k, got_f, exp_f);
            end
            if (k < last) begin
                checks++;
                if (int'(bus.o_readAdd) !== exp_ra) begin
                    errors++;
                    $display("FAIL %s read_add t0+%0d got %0d exp %0d",
                             tag, k, bus.o_readAdd, exp_ra);
                end
            end
            if (exp_we) begin
                checks++;
                if (int'(bus.o_writeAdd) !== k - LAT) begin
                    errors++;
                    $display("FAIL %s write_add t0+%0d got %0d exp %0d",
                             tag, k, bus.o_writeAdd, k - LAT);
                end
            end
        end
        bus.i_imgLength = 10'(n);
        repeat ($urandom_range(1, 4)) tick_mon();
        checks++;
        if (bus.o_state !== 3'd3 || bus.o_EoP !== 1'b1) begin
            errors++;
            $display("FAIL %s drain got %0d/%b exp 3/1",
                     tag, bus.o_state, bus.o_EoP);
        end
        bus.i_SoP = 1'b0;
        tick_mon();
        checks++;
        if (bus.o_state !== 3'd0 || bus.o_EoP !== 1'b1) begin
            errors++;
            $display("FAIL %s drain_exit got %0d/%b exp 0/1",
                     tag, bus.o_state, bus.o_EoP);
        end
    endtask

    task automatic do_read(input int n, input string tag);
        cb_cnt = 0;
        bus.i_imgLength = 10'(n);
        tick_mon();
        checks++;
        if (bus.o_state !== 3'd4 || bus.o_readAdd !== 10'd0) begin
            errors++;
            $display("FAIL %s read_enter got %0d/%0d exp 4/0",
                     tag, bus.o_state, bus.o_readAdd);
        end
        for (int i = 0; i < n; i++) begin
            bus.i_valid = 1'b1;
            tick_mon();
            checks++;
            if (int'(bus.o_readAdd) !== i + 1 || bus.o_state !== 3'd4) begin
                errors++;
                $display("FAIL %s read_add got %0d exp %0d",
                         tag, bus.o_readAdd, i + 1);
            end
            repeat ($urandom_range(0, 2)) tick_mon();
            bus.i_valid = 1'b0;
            repeat ($urandom_range(1, 3)) tick_mon();
        end
        repeat (3) tick_mon();
        bank_exp = (bank_exp + 1) % NBK;
        checks++;
        if (bus.o_EoP !== 1'b0 || cb_cnt !== 1) begin
            errors++;
            $display("FAIL %s read_done eop/cb got %b/%0d exp 0/1",
                     tag, bus.o_EoP, cb_cnt);
        end
        checks++;
        if (int'(bus.o_bankSel) !== bank_exp || bus.o_state !== 3'd0) begin
            errors++;
            $display("FAIL %s read_bank got %0d/%0d exp %0d/0",
                     tag, bus.o_bankSel, bus.o_state, bank_exp);
        end
    endtask

    task automatic test_load();
        do_load(8, 0, "load8");
    endtask

    task automatic test_proc_read();
        do_proc(8, "proc8");
        do_read(8, "read8");
    endtask

    task automatic test_rotation();
        do_load(8, 1, "rot0");
        do_load($urandom_range(K, 12), 2, "rot1");
        do_load($urandom_range(K, 12), 0, "rot2");
    endtask

    task automatic test_errors();
        for (int c = 0; c < 4; c++) begin
            logic [3:0] got;
            idle_inputs();
            err_cnt = 0;
            unique case (c)
                0: begin bus.i_load = 1'b1; bus.i_SoP = 1'b1; end
                1: begin bus.i_load = 1'b1; bus.i_imgLength = 10'd2; end
                2: begin
                    bus.i_SoP = 1'b1;
                    bus.i_imgLength = 10'($urandom_range(0, K - 1));
                end
                default: begin bus.i_load = 1'b1; bus.i_imgLength = 10'd0; end
            endcase
            tick_mon();
            got = {bus.o_err, bus.o_state};
            checks++;
            if (got !== 4'b1000) begin
                errors++;
                $display("FAIL err_case%0d pulse got %b exp 1000", c, got);
            end
            idle_inputs();
            repeat (2) tick_mon();
            got = {bus.o_err, bus.o_state};
            checks++;
            if (got !== 4'b0000 || err_cnt !== 1) begin
                errors++;
                $display("FAIL err_case%0d after got %b cnt %0d exp 0000 cnt 1",
                         c, got, err_cnt);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 4; r++) begin
            int n;
            n = $urandom_range(K, 24);
            do_load(n, $urandom_range(0, 2), "b2b_load");
            n = $urandom_range(K, 24);
            do_proc(n, "b2b_proc");
            do_read(n, "b2b_read");
        end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        bus.i_SoP = 1'b1;
        repeat (9) tick_mon();
        checks++;
        if (bus.o_wrEn !== 1'b1 || bus.o_state !== 3'd2) begin
            errors++;
            $display("FAIL rst_mid pre got %b/%0d exp 1/2",
                     bus.o_wrEn, bus.o_state);
        end
        rst = 1'b1;
        tick_mon();
        check_all_zero("rst_mid");
        bank_exp = 0;
        rst = 1'b0;
        bus.i_SoP = 1'b0;
        tick_mon();
        do_load(8, 0, "rst_mid_load");
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_load();
        test_proc_read();
        test_rotation();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
